// File: rtl/decryption_regfile_mc.sv
// Multi-channel decryption config bank: select, shadow/active keys,
// sticky lock, status and an idle-gated atomic key commit.
module decryption_regfile_mc #(
  parameter int ADDR_W = 8,
  parameter int REG_W  = 16,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2,
  parameter logic [ADDR_W-1:0] KEY_BASE = 8'h10,
  parameter logic [NUM_CH*REG_W-1:0] KEY_RST =
    {16'h2, 16'hFFFF, 16'h0}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    read,
  input  logic                    write,
  input  logic [REG_W-1:0]        wdata,
  output logic [REG_W-1:0]        rdata,
  output logic                    done,
  output logic                    error,
  input  logic                    cipher_idle,
  output logic [REG_W-1:0]        select,
  output logic [NUM_CH*REG_W-1:0] keys,
  output logic                    keys_updated
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_PEND = 1'b1;

  localparam logic [ADDR_W-1:0] A_SEL  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4);

  logic [REG_W-1:0]        rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_CH*REG_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH*REG_W-1:0] active_q, active_d;
  logic                    lock_q, lock_d;
  logic                    state_q, state_d;
  logic                    upd_q, upd_d;

  logic             is_sel, is_ctrl, is_stat;
  logic             key_hit;
  logic [3:0]       key_idx;
  logic             acc, err, wr_ok;
  logic             commit_req, apply;
  logic [REG_W-1:0] rd_val;

  always_comb begin
    is_sel  = (addr == A_SEL);
    is_ctrl = (addr == A_CTRL);
    is_stat = (addr == A_STAT);
    key_hit = 1'b0;
    key_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == KEY_BASE + ADDR_W'(2 * i)) begin
        key_hit = 1'b1;
        key_idx = 4'(i);
      end
    end

    acc   = read | write;
    err   = acc & (~(is_sel | is_ctrl | is_stat | key_hit)
                   | (write & (is_stat | lock_q)));
    wr_ok = write & ~err;

    rd_val = '0;
    unique case (1'b1)
      is_sel:  rd_val = REG_W'(sel_q);
      is_ctrl: rd_val = REG_W'(lock_q);
      is_stat: rd_val = REG_W'({lock_q, state_q == S_PEND});
      key_hit: rd_val = shadow_q[key_idx*REG_W +: REG_W];
      default: rd_val = '0;
    endcase

    sel_d    = sel_q;
    shadow_d = shadow_q;
    if (wr_ok && is_sel)
      sel_d = wdata[SEL_W-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok && key_hit && key_idx == 4'(i))
        shadow_d[i*REG_W +: REG_W] = wdata;
    end

    lock_d     = lock_q | (wr_ok & is_ctrl & wdata[0]);
    commit_req = wr_ok & is_ctrl & wdata[1];

    // Apply sees this edge's key write: copy from shadow_d.
    apply    = (state_q == S_PEND) & cipher_idle;
    active_d = apply ? shadow_d : active_q;
    upd_d    = apply;
    state_d  = state_q;
    if (apply)
      state_d = S_IDLE;
    else if (commit_req)
      state_d = S_PEND;

    rdata_d = (read & ~err) ? rd_val : '0;
    done_d  = acc;
    error_d = err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      done_q   <= 1'b1;
      error_q  <= 1'b0;
      sel_q    <= '0;
      shadow_q <= KEY_RST;
      active_q <= KEY_RST;
      lock_q   <= 1'b0;
      state_q  <= S_IDLE;
      upd_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      error_q  <= error_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      lock_q   <= lock_d;
      state_q  <= state_d;
      upd_q    <= upd_d;
    end
  end

  assign rdata        = rdata_q;
  assign done         = done_q;
  assign error        = error_q;
  assign select       = REG_W'(sel_q);
  assign keys         = active_q;
  assign keys_updated = upd_q;

endmodule
